fp_cmp_scheduler: RTL and testbench
===================================

Name: fp_cmp_scheduler

Overview:
Time-shares one fp_gt single-precision comparator among NUM_REQ indicator requesters, such as moving-average crossover or threshold checkers. Each requester presents an operand pair (a, b) with a valid/ready handshake. The scheduler grants one pair per cycle in round-robin order, runs it through a registered fp_gt stage, and returns a per-requester result (a > b) on a held valid/ready response channel. It sits between the indicator units and the trade-signal logic.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
IDX_W, 2, width of grant index; must satisfy 2**IDX_W >= NUM_REQ.
CNT_W, 16, width of the completed-comparison counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  requester i presents an operand pair.
req_ready  out  NUM_REQ  one-hot-or-zero; pair i is accepted this cycle.
req_a  in  32*NUM_REQ  operand a for requester i in bits [32i+31:32i]; IEEE-754 single.
req_b  in  32*NUM_REQ  operand b for requester i, packed the same way.
rsp_valid  out  NUM_REQ  result for requester i is available.
rsp_gt  out  NUM_REQ  result bit i: 1 when a_i > b_i per fp_gt semantics.
rsp_ready  in  NUM_REQ  requester i consumes its result.
grant_idx  out  IDX_W  index of the requester accepted this cycle; 0 when none.
busy  out  1  high while any compare stage is valid or any pend bit is set.
cmp_count  out  CNT_W  completed comparisons, saturating.

Behaviour:
- Reset (rst=1 at an edge): pend, rsp_valid, rsp_gt, stage valid, rr_ptr and cmp_count all go to 0. In-flight comparisons are discarded and no response is produced for them. req_ready=0 while rst=1.
- Eligibility: elig[i] = req_valid[i] & ~pend[i]. pend is registered, so a requester whose response is consumed in cycle T is first eligible in cycle T+1.
- Arbitration is combinational. The winner w is the first elig index scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ. req_ready[w]=1 and grant_idx=w. All other req_ready bits are 0. req_ready may depend on req_valid in the same cycle.
- Acceptance of w at edge T:
  - s_a <= a_w, s_b <= b_w, s_idx <= w, s_vld <= 1.
  - pend[w] <= 1.
  - rr_ptr <= (w+1) mod NUM_REQ.
  - With no grant: s_vld <= 0 and rr_ptr is unchanged.
- Compare stage (cycle T+1): one fp_gt instance evaluates s_a, s_b combinationally. At edge T+1, if s_vld: rsp_gt[s_idx] <= result, rsp_valid[s_idx] <= 1, and cmp_count increments (holds at 2**CNT_W-1). Latency from acceptance to rsp_valid is exactly 2 cycles. Throughput is one comparison per cycle, aggregate.
- fp_gt semantics, required bit-exact:
  - Signs differ: result = ~a[31].
  - Both positive: result = a[30:0] > b[30:0].
  - Both negative: result = ~(a[30:0] > b[30:0]). Equal negative operands therefore give 1.
  - +0 vs -0 gives 1.
  - NaN is not special-cased.
- Response: rsp_valid[i] and rsp_gt[i] hold stable until rsp_valid[i] & rsp_ready[i] at an edge, which clears rsp_valid[i] and pend[i]. rsp_ready while rsp_valid=0 has no effect.
- At most one outstanding pair per requester, so a stage write never collides with a held response.
- Simultaneous events in one cycle: a grant to j, a stage write to k and a response handshake on m are independent and all take effect.
- busy = s_vld | (|pend).

Test Plan:
1. Single request: after reset, req_valid[0]=1, a=0x40400000 (3.0), b=0x40000000 (2.0), rsp_ready=1 -> req_ready[0]=1 in cycle 0, rsp_valid[0]=1 with rsp_gt[0]=1 in cycle 2 only, cmp_count=1.
2. Round-robin fairness: all four req_valid held high, rsp_ready=all 1 -> grant_idx sequence 0,1,2,3, then 0 once pend[0] clears; no requester is granted twice before the others; rsp_valid bits assert in the same order, 2 cycles after each grant.
3. Sign/edge cases on requester 2:
   - a=0xBF800000 (-1.0), b=0xC0000000 (-2.0) -> 1.
   - a=b=0xC0000000 -> 1.
   - a=0x00000000, b=0x80000000 -> 1.
   - a=0x80000000, b=0x00000000 -> 0.
   - a=b=0x40000000 -> 0.
4. Backpressure: rsp_ready[1]=0 with req_valid[1] held high -> after the first grant, req_ready[1] stays 0 and rsp_valid[1]/rsp_gt[1] stay stable while requesters 0, 2 and 3 keep being granted; raising rsp_ready[1] for one cycle -> requester 1 is granted again on the next eligible cycle.
5. Reset mid-flight: assert rst the cycle after a grant to requester 3 -> next cycle shows rsp_valid=0, busy=0, cmp_count=0, rr_ptr=0; no response ever appears for the discarded pair.
6. Counter saturation (CNT_W=4 build): 20 back-to-back comparisons -> cmp_count stops at 15 and does not wrap.

Source files
------------

// File: rtl/fp_cmp_scheduler.sv
// Round-robin scheduler sharing one registered fp_gt comparator
// among NUM_REQ requesters with held per-requester responses.
module fp_cmp_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [NUM_REQ-1:0]     rsp_gt,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic [CNT_W-1:0]       cmp_count
);

  localparam int JW = IDX_W + 1;

  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] wr_oh;
  logic [NUM_REQ-1:0] hs;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   s_idx;
  logic               win_vld;
  logic               grant;
  logic               gt;
  logic               s_vld;
  logic [31:0]        s_a;
  logic [31:0]        s_b;
  logic [31:0]        a_sel;
  logic [31:0]        b_sel;

  // Negative operands compare by inverted magnitude; equal negatives give 1.
  function automatic logic fp_gt(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic mag_gt;
    mag_gt = a[30:0] > b[30:0];
    if (a[31] != b[31]) return ~a[31];
    else if (a[31])     return ~mag_gt;
    else                return mag_gt;
  endfunction

  assign elig = req_valid & ~pend;

  always_comb begin
    logic [JW-1:0] jj;
    win_vld = 1'b0;
    win     = '0;
    jj      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      jj = {1'b0, rr_ptr} + JW'(k);
      if (jj >= JW'(NUM_REQ)) jj = jj - JW'(NUM_REQ);
      if (!win_vld && elig[jj[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win     = jj[IDX_W-1:0];
      end
    end
  end

  assign grant     = win_vld & ~rst;
  assign grant_oh  = grant ? (NUM_REQ'(1) << win) : '0;
  assign req_ready = grant_oh;
  assign grant_idx = grant ? win : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_oh[k]) begin
        a_sel = req_a[32*k +: 32];
        b_sel = req_b[32*k +: 32];
      end
    end
  end

  assign hs    = rsp_valid & rsp_ready;
  assign wr_oh = s_vld ? (NUM_REQ'(1) << s_idx) : '0;
  assign gt    = fp_gt(s_a, s_b);
  assign busy  = s_vld | (|pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      rsp_valid <= '0;
      rsp_gt    <= '0;
      s_vld     <= 1'b0;
      s_idx     <= '0;
      s_a       <= '0;
      s_b       <= '0;
      rr_ptr    <= '0;
      cmp_count <= '0;
    end else begin
      s_vld <= grant;
      if (grant) begin
        s_a   <= a_sel;
        s_b   <= b_sel;
        s_idx <= win;
        if (win == IDX_W'(NUM_REQ-1)) rr_ptr <= '0;
        else                          rr_ptr <= win + 1'b1;
      end
      pend      <= (pend & ~hs) | grant_oh;
      rsp_valid <= (rsp_valid & ~hs) | wr_oh;
      rsp_gt    <= (rsp_gt & ~wr_oh) | (wr_oh & {NUM_REQ{gt}});
      if (s_vld && cmp_count != '1)
        cmp_count <= cmp_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_cmp_scheduler.sv
// Directed bench for fp_cmp_scheduler: latency, round-robin,
// compare edge cases, backpressure, reset and counter saturation.
module tb_fp_cmp_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [N-1:0]   rsp_valid, rsp_gt, rsp_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [1:0]     grant_idx;
  logic           busy;
  logic [15:0]    cmp_count;

  logic [N-1:0]   s_req_valid, s_req_ready;
  logic [N-1:0]   s_rsp_valid, s_rsp_gt, s_rsp_ready;
  logic [32*N-1:0] s_req_a, s_req_b;
  logic [1:0]     s_grant_idx;
  logic           s_busy;
  logic [3:0]     s_cmp_count;

  fp_cmp_scheduler #(.NUM_REQ(N), .IDX_W(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_gt(rsp_gt),
    .rsp_ready(rsp_ready), .grant_idx(grant_idx),
    .busy(busy), .cmp_count(cmp_count)
  );

  fp_cmp_scheduler #(.NUM_REQ(N), .IDX_W(2), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_a(s_req_a), .req_b(s_req_b),
    .rsp_valid(s_rsp_valid), .rsp_gt(s_rsp_gt),
    .rsp_ready(s_rsp_ready), .grant_idx(s_grant_idx),
    .busy(s_busy), .cmp_count(s_cmp_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic set_op(input int i,
                        input logic [31:0] a,
                        input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    s_req_valid = '0;
    s_rsp_ready = '0;
    @(negedge clk);
    req_valid = '1;
    #1 chk("rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(cmp_count), 0);
  endtask

  task automatic run_one(input string tag, input int i,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic exp);
    @(negedge clk);
    set_op(i, a, b);
    req_valid = 4'(1) << i;
    rsp_ready = '1;
    #1 chk({tag, "_ready"}, 32'(req_ready), 32'(4'(1) << i));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk({tag, "_c1_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_c1_busy"}, 32'(busy), 1);
    @(negedge clk);
    #1;
    chk({tag, "_c2_valid"}, 32'(rsp_valid), 32'(4'(1) << i));
    chk({tag, "_gt"}, 32'(rsp_gt[i]), 32'(exp));
    @(negedge clk);
    #1 chk({tag, "_c3_valid"}, 32'(rsp_valid), 0);
  endtask

  int seq4 [10] = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3};

  initial begin
    req_a = '0; req_b = '0;
    s_req_a = '0; s_req_b = '0;

    // single request
    do_reset;
    run_one("t1", 0, 32'h40400000, 32'h40000000, 1'b1);
    chk("t1_count", 32'(cmp_count), 1);

    // round robin, even requesters a>b, odd a<b
    do_reset;
    for (int i = 0; i < N; i++) begin
      if (i % 2 == 0) set_op(i, 32'h40400000, 32'h40000000);
      else            set_op(i, 32'h40000000, 32'h40400000);
    end
    rsp_ready = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) begin
        chk("t2_grant", 32'(grant_idx), c % 4);
        chk("t2_ready", 32'(req_ready), 32'(4'(1) << (c % 4)));
      end
      if (c >= 2) begin
        chk("t2_rsp_valid", 32'(rsp_valid),
            32'(4'(1) << ((c - 2) % 4)));
        chk("t2_rsp_gt", 32'(rsp_gt[(c - 2) % 4]),
            32'(((c - 2) % 2) == 0));
      end
    end
    @(negedge clk);
    #1;
    chk("t2_count", 32'(cmp_count), 8);
    chk("t2_busy", 32'(busy), 0);

    // sign and edge cases on requester 2
    run_one("t3_neg",  2, 32'hBF800000, 32'hC0000000, 1'b1);
    run_one("t3_eqn",  2, 32'hC0000000, 32'hC0000000, 1'b1);
    run_one("t3_pz",   2, 32'h00000000, 32'h80000000, 1'b1);
    run_one("t3_nz",   2, 32'h80000000, 32'h00000000, 1'b0);
    run_one("t3_eqp",  2, 32'h40000000, 32'h40000000, 1'b0);

    // backpressure on requester 1
    do_reset;
    for (int i = 0; i < N; i++) set_op(i, 32'h0, 32'h0);
    set_op(1, 32'h40A00000, 32'h3F800000);
    rsp_ready = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      chk("t4_grant", 32'(grant_idx), seq4[c]);
      chk("t4_ready1", 32'(req_ready[1]), 32'(c == 1));
      if (c >= 3) begin
        chk("t4_hold_valid", 32'(rsp_valid[1]), 1);
        chk("t4_hold_gt", 32'(rsp_gt[1]), 1);
      end
    end
    @(negedge clk);
    rsp_ready = 4'b1111;
    #1;
    chk("t4_c10_grant", 32'(grant_idx), 0);
    chk("t4_c10_valid1", 32'(rsp_valid[1]), 1);
    @(negedge clk);
    rsp_ready = 4'b1101;
    #1;
    chk("t4_regrant", 32'(grant_idx), 1);
    chk("t4_c11_valid1", 32'(rsp_valid[1]), 0);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) @(negedge clk);
    #1 chk("t4_drain_busy", 32'(busy), 0);

    // reset mid-flight
    do_reset;
    set_op(3, 32'h40400000, 32'h40000000);
    rsp_ready = '1;
    @(negedge clk);
    req_valid = 4'b1000;
    #1 chk("t5_grant", 32'(grant_idx), 3);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'hF;
    #1 chk("t5_rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_count", 32'(cmp_count), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("t5_no_rsp", 32'(rsp_valid), 0);
    end
    @(negedge clk);
    req_valid = 4'hF;
    #1 chk("t5_rr_ptr", 32'(grant_idx), 0);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);

    // saturating counter on the CNT_W=4 instance
    do_reset;
    s_rsp_ready = '1;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      s_req_valid = (c < 20) ? 4'hF : 4'h0;
      #1;
      if (c == 8)  chk("t6_count8", 32'(s_cmp_count), 7);
      if (c == 16) chk("t6_count16", 32'(s_cmp_count), 15);
      if (c == 17) chk("t6_count17", 32'(s_cmp_count), 15);
    end
    chk("t6_final", 32'(s_cmp_count), 15);
    chk("t6_busy", 32'(s_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
